// File: rtl/add8_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : add8_arbiter_if
// Description : Requester/response bundle for the shared 8-bit adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface add8_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_chain;
  logic [NUM_REQ-1:0]   req_cin;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_sum;
  logic                 rsp_cout;

  modport master (
    output req_valid, req_chain, req_cin, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_chain, req_cin, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface
`default_nettype wire

// File: rtl/add8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add8_arbiter
// Description : Round-robin sharing of a two-stage 8-bit adder with per-
//               requester carry registers for chained wide additions.
// Revision    : 1.0 - initial release
// ============================================================================
module add8_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk_100M,
  input  logic               rst,
  add8_arbiter_if.slave      bus
);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] inflight_q, inflight_d;
  logic [NUM_REQ-1:0] carry_q, carry_d;

  logic               s1_valid_q;
  logic [ID_W-1:0]    s1_id_q;
  logic [3:0]         s1_lo_q;
  logic               s1_c_q;
  logic [3:0]         s1_ah_q;
  logic [3:0]         s1_bh_q;

  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [7:0]         rsp_sum_q;
  logic               rsp_cout_q;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;
  logic [ID_W-1:0]    w_gnt_id;
  logic [7:0]         w_a;
  logic [7:0]         w_b;
  logic               w_cin;
  logic [4:0]         w_lo;
  logic [4:0]         w_hi;

  assign w_elig = bus.req_valid & ~inflight_q;

  // Two passes give a rotating priority: indices at/after the pointer win first.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_accept = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_accept && (ID_W'(i) >= rr_ptr_q) && w_elig[i]) begin
        w_accept   = 1'b1;
        w_grant[i] = 1'b1;
        w_gnt_id   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_accept && (ID_W'(i) < rr_ptr_q) && w_elig[i]) begin
        w_accept   = 1'b1;
        w_grant[i] = 1'b1;
        w_gnt_id   = ID_W'(i);
      end
    end
    if (rst) begin
      w_grant  = '0;
      w_accept = 1'b0;
    end
  end

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a   = bus.req_a[8*i +: 8];
        w_b   = bus.req_b[8*i +: 8];
        w_cin = bus.req_chain[i] ? carry_q[i] : bus.req_cin[i];
      end
    end
  end

  assign w_lo = {1'b0, w_a[3:0]} + {1'b0, w_b[3:0]} + {4'b0000, w_cin};
  assign w_hi = {1'b0, s1_ah_q} + {1'b0, s1_bh_q} + {4'b0000, s1_c_q};

  // A response and a new accept never share an id, so both updates can merge.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    carry_d    = carry_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid_q && (rsp_id_q == ID_W'(i))) begin
        inflight_d[i] = 1'b0;
        carry_d[i]    = rsp_cout_q;
      end
    end
    if (w_accept) begin
      inflight_d = inflight_d | w_grant;
      rr_ptr_d   = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      inflight_q  <= '0;
      carry_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_ah_q     <= '0;
      s1_bh_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
      carry_q     <= carry_d;
      s1_valid_q  <= w_accept;
      s1_id_q     <= w_gnt_id;
      s1_lo_q     <= w_lo[3:0];
      s1_c_q      <= w_lo[4];
      s1_ah_q     <= w_a[7:4];
      s1_bh_q     <= w_b[7:4];
      rsp_valid_q <= s1_valid_q;
      rsp_id_q    <= s1_id_q;
      rsp_sum_q   <= {w_hi[3:0], s1_lo_q};
      rsp_cout_q  <= w_hi[4];
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;

endmodule
`default_nettype wire

// File: tb/tb_add8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_add8_arbiter
// Description : Randomised and directed bench for add8_arbiter with a
//               cycle-level reference model of grants and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add8_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk_100M = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_100M = ~clk_100M;

  logic [NUM_REQ-1:0]   v  = '0;
  logic [NUM_REQ-1:0]   ch = '0;
  logic [NUM_REQ-1:0]   ci = '0;
  logic [8*NUM_REQ-1:0] a  = '0;
  logic [8*NUM_REQ-1:0] b  = '0;

  add8_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  assign bus.req_valid = v;
  assign bus.req_chain = ch;
  assign bus.req_cin   = ci;
  assign bus.req_a     = a;
  assign bus.req_b     = b;

  add8_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timing rules expressed as cycle numbers and a due-queue
  typedef struct {
    int         due;
    int         id;
    logic [8:0] full;
  } rsp_t;

  rsp_t               q[$];
  int                 cyc = 0;
  int                 rr_m = 0;
  int                 busy_until[NUM_REQ];
  bit                 carry_m[NUM_REQ];
  logic [NUM_REQ-1:0] acc_mask = '0;
  logic [NUM_REQ-1:0] m_ready;
  int                 m_i;
  int                 m_g;
  bit                 m_v;
  logic               m_cin;
  logic [8:0]         m_full;
  rsp_t               m_e;

  always @(negedge clk_100M) begin
    m_ready = '0;
    m_g     = -1;
    if (!rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        m_i = (rr_m + off) % NUM_REQ;
        if (m_g < 0 && bus.req_valid[m_i] && cyc >= busy_until[m_i]) begin
          m_g          = m_i;
          m_ready[m_i] = 1'b1;
        end
      end
    end
    chk("req_ready", 32'(bus.req_ready), 32'(m_ready));

    m_v = (q.size() > 0) && (q[0].due == cyc);
    if (!rst) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_v));
      if (m_v) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        chk("rsp_sum", 32'(bus.rsp_sum), 32'(q[0].full[7:0]));
        chk("rsp_cout", 32'(bus.rsp_cout), 32'(q[0].full[8]));
      end
    end

    if (rst) begin
      q.delete();
      rr_m = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        busy_until[i] = 0;
        carry_m[i]    = 1'b0;
      end
      acc_mask = '0;
    end else begin
      if (m_v) begin
        carry_m[q[0].id] = q[0].full[8];
        void'(q.pop_front());
      end
      if (m_g >= 0) begin
        m_cin  = bus.req_chain[m_g] ? carry_m[m_g] : bus.req_cin[m_g];
        m_full = {1'b0, bus.req_a[8*m_g +: 8]} + {1'b0, bus.req_b[8*m_g +: 8]} + {8'd0, m_cin};
        m_e.due  = cyc + 2;
        m_e.id   = m_g;
        m_e.full = m_full;
        q.push_back(m_e);
        busy_until[m_g] = cyc + 3;
        rr_m = (m_g + 1) % NUM_REQ;
      end
      acc_mask = m_ready;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic set_op(input int id, input logic [7:0] aa, input logic [7:0] bb,
                        input logic c, input logic chn);
    a[8*id +: 8] = aa;
    b[8*id +: 8] = bb;
    ci[id]       = c;
    ch[id]       = chn;
  endtask

  task automatic issue(input int id, input logic [7:0] aa, input logic [7:0] bb,
                       input logic c, input logic chn);
    bit ok;
    set_op(id, aa, bb, c, chn);
    v[id] = 1'b1;
    ok    = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk_100M);
      if (bus.req_ready[id]) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requester %0d never granted", id);
    end
    tick();
    v[id] = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input int id, input logic [7:0] s, input logic co);
    @(negedge clk_100M);
    chk({name, "_early"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk_100M);
    chk({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({name, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({name, "_sum"}, 32'(bus.rsp_sum), 32'(s));
    chk({name, "_cout"}, 32'(bus.rsp_cout), 32'(co));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  bit pend[NUM_REQ];

  initial begin
    idle(3);
    rst = 1'b0;
    @(negedge clk_100M);
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    chk("reset_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    tick();

    // Single operation
    issue(1, 8'h3C, 8'h47, 1'b1, 1'b0);
    expect_rsp("single", 1, 8'h84, 1'b0);
    tick();

    // Overflow then chained bytes
    issue(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    expect_rsp("ovf", 0, 8'h00, 1'b1);
    tick();
    issue(0, 8'h12, 8'h34, 1'b0, 1'b1);
    expect_rsp("chain1", 0, 8'h47, 1'b0);
    tick();
    issue(0, 8'h00, 8'h00, 1'b1, 1'b1);
    expect_rsp("chain0", 0, 8'h00, 1'b0);
    idle(3);

    // Fairness: all valid from reset
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i * 17), 8'(i * 3), 1'b0, 1'b0);
    v = '1;
    idle(2);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk_100M);
      chk("fair_grant", 32'(bus.req_ready), 32'(1 << (n % NUM_REQ)));
    end
    tick();
    v = '0;
    idle(4);

    // Spacing: lone requester 2 every third cycle
    set_op(2, 8'h05, 8'h06, 1'b0, 1'b0);
    v[2] = 1'b1;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk_100M);
      chk("spacing_ready2", 32'(bus.req_ready[2]), 32'((n % 3) == 0));
    end
    tick();
    v = '0;
    idle(4);

    // Reset with two operations in flight
    set_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    set_op(1, 8'h20, 8'h30, 1'b0, 1'b0);
    v = 4'b0011;
    @(negedge clk_100M);
    chk("rstmid_grant0", 32'(bus.req_ready), 32'b0001);
    @(negedge clk_100M);
    chk("rstmid_grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    v   = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_100M);
      chk("rstmid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    set_op(0, 8'h10, 8'h20, 1'b1, 1'b1);
    set_op(1, 8'h01, 8'h02, 1'b0, 1'b0);
    v = 4'b0011;
    @(negedge clk_100M);
    chk("post_rst_first", 32'(bus.req_ready), 32'b0001);
    tick();
    v[0] = 1'b0;
    @(negedge clk_100M);
    chk("post_rst_second", 32'(bus.req_ready), 32'b0010);
    tick();
    v[1] = 1'b0;
    @(negedge clk_100M);
    chk("post_rst_chain_valid", 32'(bus.rsp_valid), 32'd1);
    chk("post_rst_chain_sum", 32'(bus.rsp_sum), 32'h30);
    idle(4);

    // Withdrawal of requester 3 while 2 is served
    set_op(2, 8'h11, 8'h22, 1'b0, 1'b0);
    set_op(3, 8'h33, 8'h44, 1'b0, 1'b0);
    v = 4'b1100;
    @(negedge clk_100M);
    chk("wd_grant2", 32'(bus.req_ready), 32'b0100);
    tick();
    v = '0;
    @(negedge clk_100M);
    @(negedge clk_100M);
    chk("wd_rsp_id", 32'(bus.rsp_id), 32'd2);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk_100M);
      chk("wd_no_rsp3", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    v = 4'b1001;
    @(negedge clk_100M);
    chk("wd_ptr", 32'(bus.req_ready), 32'b1000);
    tick();
    v = '0;
    idle(4);

    // Randomised traffic with withdrawals and occasional reset
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i]) pend[i] = 1'b0;
        if (pend[i]) begin
          if ($urandom_range(0, 15) == 0) begin
            pend[i] = 1'b0;
            v[i]    = 1'b0;
          end
        end else if ($urandom_range(0, 2) != 0) begin
          set_op(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
          pend[i] = 1'b1;
          v[i]    = 1'b1;
        end else begin
          v[i] = 1'b0;
          set_op(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
      end
    end
    tick();
    rst = 1'b0;
    v   = '0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

endmodule
`default_nettype wire

// File: doc/add8_arbiter.md
# add8_arbiter

Round-robin controller that shares one two-stage pipelined 8-bit carry adder between `NUM_REQ` requesters. It accepts at most one operation per cycle and tags each operation with its requester index. It returns sum and carry-out on a shared response port two cycles later. Each requester keeps a carry register, so a requester can chain byte-wise adds to build wider sums without holding the datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: requester-index width, equal to max(1, clog2(`NUM_REQ`)).
- `clk_100M` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: bit i set means requester i presents an operation.
- `req_chain` in `NUM_REQ`: bit i set means use requester i's stored carry instead of `req_cin[i]`.
- `req_cin` in `NUM_REQ`: explicit carry-in per requester.
- `req_a` in 8*`NUM_REQ`: operand A; requester i uses bits [8i+7:8i].
- `req_b` in 8*`NUM_REQ`: operand B, same packing as `req_a`.
- `req_ready` out `NUM_REQ`: one-hot or zero grant; an operation is accepted when valid and ready are both high in the same cycle.
- `rsp_valid` out 1: result present this cycle.
- `rsp_id` out `ID_W`: requester index of the result.
- `rsp_sum` out 8: sum bits [7:0].
- `rsp_cout` out 1: carry-out, bit 8 of the sum.

## Operation
- Requester i is eligible when `req_valid[i]` is high and `inflight[i]` is 0.
- The arbiter grants the first eligible index at or after `rr_ptr`, searching upward modulo `NUM_REQ`.
  - `req_ready` is combinational from registered state and `req_valid`.
  - There is at most one grant per cycle.
  - On an accept by requester g: `rr_ptr` becomes (g+1) mod `NUM_REQ` and `inflight[g]` is set.
  - With no accept, `rr_ptr` holds.
- A requester must hold valid, operands, chain and cin stable until it is accepted. Dropping valid before acceptance withdraws the request with no side effect.
- Effective carry-in is `carry_reg[i]` when `req_chain[i]` is high, otherwise `req_cin[i]`.
- Arithmetic: {cout, sum} = a + b + cin, computed unsigned at 9-bit width.
- The datapath is split into two stages:
  - Stage 1 registers the low nibble sum, its carry, the high nibbles of a and b, the id and a valid bit.
  - Stage 2 adds the high nibbles plus the stage-1 carry and registers the full 8-bit sum and cout.
- The pipeline never stalls; the response port has no backpressure and every result must be consumed the cycle it appears.
- In the response cycle for requester id:
  - `carry_reg[id]` is loaded with `rsp_cout`.
  - `inflight[id]` is cleared at the same edge.
- Chained wide add: byte 0 is issued with chain=0 and the wanted cin; each higher byte is issued with chain=1. `carry_reg` keeps its value between chained operations and changes only on that requester's responses.
- Reset clears:
  - every output to 0;
  - `rr_ptr` to 0;
  - all `inflight` bits;
  - both stage-valid bits;
  - all `carry_reg` bits.
- Reset mid-operation discards all in-flight operations, and no response is produced for them.

## Timing
- Latency: an accept in cycle k gives `rsp_valid` in cycle k+2 with that operation's id, sum and cout.
- Aggregate throughput is one operation per cycle.
- Per-requester reissue: an accept at k makes that requester ineligible in k+1 and k+2 and eligible again from k+3. This guarantees the chained carry is up to date at reissue.
- Full throughput therefore needs at least 3 requesters with pending work.
- `rst` sampled high at an edge forces reset state after that edge. `req_ready` is 0 in any cycle where `rst` is high.
- When a response and a new accept happen in the same cycle (different ids), both state updates take effect at the same edge.

## Test plan
- Single operation: requester 1 sends a=0x3C, b=0x47, cin=1 -> `rsp_valid` exactly 2 cycles after accept, `rsp_id`=1, sum=0x84, cout=0.
- Overflow and chaining:
  - Requester 0 sends 0xFF+0x01, cin=0, chain=0 -> sum=0x00, cout=1.
  - It then sends 0x12+0x34 with chain=1 -> sum=0x47, cout=0, and `carry_reg[0]` becomes 0.
- Fairness: all four requesters hold valid continuously from reset -> grant order 0,1,2,3,0,1... with one accept per cycle and no cycle without a grant.
- Spacing: only requester 2 holds valid continuously -> accepts at cycles k, k+3, k+6, with `req_ready[2]` low in between.
- Reset mid-operation:
  - Accept ops from requesters 0 and 1, then assert `rst` the next cycle -> no `rsp_valid` appears.
  - After `rst` is released, requester 0 is granted first, and a chain=1 op from requester 0 uses carry 0.
- Withdrawal: requester 3 asserts valid while requester 2 is granted, then drops valid before its grant -> no response for id 3, and `rr_ptr` follows only actual accepts.
